// File: rtl/pe_ws_db.sv
// Weight-stationary PE with ping-pong weight banks; psum_out = psum_in + (w[sel]*feat)>>>FRAC_W after 1 cycle.
// No backpressure: weights fill the shadow bank and are forwarded south once it is full. Optional macro PE_SAT_EN enables saturation.
module pe_ws_db #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int NUM_W  = 4,
    parameter int FRAC_W = 0,
    localparam int SEL_W = $clog2(NUM_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wt_in_valid,
    input  logic [DATA_W-1:0] wt_in,
    output logic              wt_out_valid,
    output logic [DATA_W-1:0] wt_out,
    input  logic              swap,
    output logic              swap_ack,
    output logic              shadow_full,
    input  logic              feat_valid,
    input  logic [DATA_W-1:0] feat_in,
    input  logic [SEL_W-1:0]  feat_sel,
    output logic              feat_out_valid,
    output logic [DATA_W-1:0] feat_out,
    output logic [SEL_W-1:0]  feat_sel_out,
    input  logic [ACC_W-1:0]  psum_in,
    output logic              psum_out_valid,
    output logic [ACC_W-1:0]  psum_out,
    output logic              sat_flag
);

    localparam int PW = 2 * DATA_W;
    localparam int WW = (PW > ACC_W) ? PW : ACC_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_W - 1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                        state_q, state_d;
    logic                          load_en, swap_acc;
    logic [SEL_W-1:0]              ptr;
    logic                          act;
    logic [NUM_W-1:0][DATA_W-1:0]  bank0, bank1;

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        swap_acc = 1'b0;
        case (state_q)
            FILL: begin
                if (wt_in_valid) begin
                    load_en = 1'b1;
                    if (ptr == LAST) state_d = FULL;
                end
            end
            FULL: begin
                if (swap) begin
                    swap_acc = 1'b1;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (clr) begin
            state_d  = FILL;
            load_en  = 1'b0;
            swap_acc = 1'b0;
        end
    end

    assign shadow_full = (state_q == FULL);

    // The shadow bank is always the one not selected by act.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            ptr      <= '0;
            act      <= 1'b0;
            swap_ack <= 1'b0;
            bank0    <= '0;
            bank1    <= '0;
        end else begin
            state_q  <= state_d;
            swap_ack <= swap_acc;
            if (clr || swap_acc) begin
                ptr <= '0;
            end else if (load_en) begin
                ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
            end
            if (swap_acc) act <= ~act;
            if (load_en) begin
                if (act) bank0[ptr] <= wt_in;
                else     bank1[ptr] <= wt_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_out_valid <= 1'b0;
            wt_out       <= '0;
        end else if (clr) begin
            wt_out_valid <= 1'b0;
        end else begin
            wt_out_valid <= (state_q == FULL) && wt_in_valid;
            if ((state_q == FULL) && wt_in_valid) wt_out <= wt_in;
        end
    end

    logic [DATA_W-1:0]        w_act;
    logic signed [PW-1:0]     prod, sh;
    logic signed [WW-1:0]     sh_wide;
    logic [ACC_W-1:0]         psum_nxt;

    assign w_act   = act ? bank1[feat_sel] : bank0[feat_sel];
    assign prod    = $signed(w_act) * $signed(feat_in);
    assign sh      = prod >>> FRAC_W;
    assign sh_wide = sh;

`ifdef PE_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  sh_low;
    logic signed [WW-1:0]     sh_back;
    logic [ACC_W-1:0]         sh_acc;
    logic [ACC_W:0]           sum_wide;
    logic                     trunc_ovf, add_ovf, sat_q;

    // Truncation overflows when the narrowed value no longer sign-extends back to the original.
    assign sh_low    = sh_wide[ACC_W-1:0];
    assign sh_back   = sh_low;
    assign trunc_ovf = (sh_back != sh_wide);
    assign sh_acc    = trunc_ovf ? (sh_wide[WW-1] ? ACC_MIN : ACC_MAX) : sh_low;
    assign sum_wide  = {psum_in[ACC_W-1], psum_in} + {sh_acc[ACC_W-1], sh_acc};
    assign add_ovf   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign psum_nxt  = add_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    sat_q <= 1'b0;
        else if (clr)                                  sat_q <= 1'b0;
        else if (feat_valid && (trunc_ovf || add_ovf)) sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    assign psum_nxt = psum_in + sh_wide[ACC_W-1:0];
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_out_valid <= 1'b0;
            feat_out       <= '0;
            feat_sel_out   <= '0;
            psum_out_valid <= 1'b0;
            psum_out       <= '0;
        end else begin
            feat_out_valid <= feat_valid && !clr;
            psum_out_valid <= feat_valid && !clr;
            if (feat_valid && !clr) begin
                feat_out     <= feat_in;
                feat_sel_out <= feat_sel;
                psum_out     <= psum_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pe_ws_db.sv
// Directed bench for pe_ws_db: a FRAC_W=0 instance plus a FRAC_W=4 instance sharing all inputs.
module tb_pe_ws_db;

    logic        clk, rst_n, clr;
    logic        wt_in_valid, swap, feat_valid;
    logic [15:0] wt_in, feat_in;
    logic [1:0]  feat_sel;
    logic [31:0] psum_in;

    logic        wt_out_valid, swap_ack, shadow_full, feat_out_valid, psum_out_valid, sat_flag;
    logic [15:0] wt_out, feat_out;
    logic [1:0]  feat_sel_out;
    logic [31:0] psum_out;

    logic        u1_wt_out_valid, u1_swap_ack, u1_shadow_full, u1_feat_out_valid, u1_psum_out_valid, u1_sat_flag;
    logic [15:0] u1_wt_out, u1_feat_out;
    logic [1:0]  u1_feat_sel_out;
    logic [31:0] u1_psum_out;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] acc;

`ifdef PE_SAT_EN
    localparam logic [31:0] EXP_POS = 32'h7FFFFFFF;
    localparam logic [31:0] EXP_NEG = 32'h80000000;
    localparam logic        EXP_SF  = 1'b1;
`else
    localparam logic [31:0] EXP_POS = 32'hBFFF0000;
    localparam logic [31:0] EXP_NEG = 32'h4000FFFF;
    localparam logic        EXP_SF  = 1'b0;
`endif

    pe_ws_db #(.DATA_W(16), .ACC_W(32), .NUM_W(4), .FRAC_W(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wt_in_valid(wt_in_valid), .wt_in(wt_in),
        .wt_out_valid(wt_out_valid), .wt_out(wt_out),
        .swap(swap), .swap_ack(swap_ack), .shadow_full(shadow_full),
        .feat_valid(feat_valid), .feat_in(feat_in), .feat_sel(feat_sel),
        .feat_out_valid(feat_out_valid), .feat_out(feat_out), .feat_sel_out(feat_sel_out),
        .psum_in(psum_in), .psum_out_valid(psum_out_valid), .psum_out(psum_out),
        .sat_flag(sat_flag)
    );

    pe_ws_db #(.DATA_W(16), .ACC_W(32), .NUM_W(4), .FRAC_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wt_in_valid(wt_in_valid), .wt_in(wt_in),
        .wt_out_valid(u1_wt_out_valid), .wt_out(u1_wt_out),
        .swap(swap), .swap_ack(u1_swap_ack), .shadow_full(u1_shadow_full),
        .feat_valid(feat_valid), .feat_in(feat_in), .feat_sel(feat_sel),
        .feat_out_valid(u1_feat_out_valid), .feat_out(u1_feat_out), .feat_sel_out(u1_feat_sel_out),
        .psum_in(psum_in), .psum_out_valid(u1_psum_out_valid), .psum_out(u1_psum_out),
        .sat_flag(u1_sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        wt_in_valid = 1'b1;
        wt_in       = w;
        tick();
        wt_in_valid = 1'b0;
    endtask

    task automatic feed(input logic [15:0] f, input logic [1:0] s, input logic [31:0] p);
        feat_valid = 1'b1;
        feat_in    = f;
        feat_sel   = s;
        psum_in    = p;
        tick();
        feat_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; wt_in_valid = 1'b0; wt_in = '0; swap = 1'b0;
        feat_valid = 1'b0; feat_in = '0; feat_sel = '0; psum_in = '0;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_psum_out", psum_out, 0);
        chk("rst_psum_vld", psum_out_valid, 0);
        chk("rst_wt_out_vld", wt_out_valid, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_shadow_full", shadow_full, 0);
        chk("rst_feat_vld", feat_out_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;
        tick();

        // Basic load, swap and compute.
        load_word(16'd1); load_word(16'd2); load_word(16'd3);
        chk("t1_not_full_3", shadow_full, 0);
        load_word(16'd4);
        chk("t1_full_4", shadow_full, 1);
        swap = 1'b1; tick(); swap = 1'b0;
        chk("t1_swap_ack", swap_ack, 1);
        chk("t1_full_clr", shadow_full, 0);
        feed(16'd5, 2'd2, 32'd10);
        chk("t1_swap_ack_once", swap_ack, 0);
        chk("t1_psum", psum_out, 32'd25);
        chk("t1_psum_vld", psum_out_valid, 1);
        chk("t1_feat_out", feat_out, 16'd5);
        chk("t1_sel_out", feat_sel_out, 2'd2);
        chk("t1_feat_vld", feat_out_valid, 1);
        tick();
        chk("t1_idle_vld", psum_out_valid, 0);
        chk("t1_idle_hold", psum_out, 32'd25);
        chk("t1_idle_fvld", feat_out_valid, 0);

        // Overflow words are forwarded south once the shadow bank is full.
        wt_in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wt_in = 16'(i);
            tick();
            if (i == 4) begin
                chk("t2_full", shadow_full, 1);
                chk("t2_no_fwd", wt_out_valid, 0);
            end
            if (i >= 5) begin
                chk("t2_fwd_vld", wt_out_valid, 1);
                chk("t2_fwd_dat", wt_out, 16'(i));
            end
        end
        wt_in_valid = 1'b0;
        tick();
        chk("t2_fwd_idle", wt_out_valid, 0);
        swap = 1'b1; tick(); swap = 1'b0;
        chk("t2_swap_ack", swap_ack, 1);

        // Swap while still filling is ignored.
        load_word(16'd7); load_word(16'd8);
        swap = 1'b1; tick(); swap = 1'b0;
        chk("t3_no_ack", swap_ack, 0);
        feed(16'd3, 2'd0, 32'd0);
        chk("t3_old_bank", psum_out, 32'd3);

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_full", shadow_full, 0);

        // Stream with concurrent load, then swap in the middle of the stream.
        acc = 32'd100;
        feat_valid = 1'b1; feat_in = 16'd1; feat_sel = 2'd3;
        for (int i = 1; i <= 4; i++) begin
            wt_in_valid = 1'b1; wt_in = 16'(10 * i); psum_in = acc;
            tick();
            acc = acc + 32'd4;
            chk("t4_stream", psum_out, acc);
        end
        wt_in_valid = 1'b0;
        chk("t4_full", shadow_full, 1);
        swap = 1'b1; psum_in = acc; tick(); swap = 1'b0;
        acc = acc + 32'd4;
        chk("t4_swap_cycle", psum_out, acc);
        chk("t4_swap_ack", swap_ack, 1);
        psum_in = acc; tick();
        acc = acc + 32'd40;
        chk("t4_new_bank", psum_out, acc);
        feat_valid = 1'b0;

        // Saturation / wraparound at both extremes.
        load_word(16'h7FFF); load_word(16'd0); load_word(16'd0); load_word(16'd0);
        swap = 1'b1; tick(); swap = 1'b0;
        feed(16'h7FFF, 2'd0, 32'h7FFFFFFF);
        chk("t5_pos", psum_out, EXP_POS);
        chk("t5_pos_flag", sat_flag, EXP_SF);
        tick();
        chk("t5_flag_sticky", sat_flag, EXP_SF);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t5_flag_clr", sat_flag, 0);
        feed(16'h8001, 2'd0, 32'h80000000);
        chk("t5_neg", psum_out, EXP_NEG);
        chk("t5_neg_flag", sat_flag, EXP_SF);
        clr = 1'b1; tick(); clr = 1'b0;

        // Quantizing shift on the FRAC_W=4 instance.
        load_word(16'hFFF0); load_word(16'd0); load_word(16'd0); load_word(16'd0);
        swap = 1'b1; tick(); swap = 1'b0;
        feed(16'd2, 2'd0, 32'd0);
        chk("t5_frac4", u1_psum_out, 32'hFFFFFFFE);
        chk("t5_frac0", psum_out, 32'hFFFFFFE0);

        // Reset in the middle of a load.
        load_word(16'd9); load_word(16'd9);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_psum", psum_out, 0);
        chk("t6_rst_feat", feat_out, 0);
        chk("t6_rst_full", shadow_full, 0);
        tick();
        rst_n = 1'b1;
        tick();
        feed(16'd5, 2'd0, 32'd7);
        chk("t6_bank_zero", psum_out, 32'd7);
        load_word(16'd2); load_word(16'd3); load_word(16'd4);
        chk("t6_ptr_reset", shadow_full, 0);
        load_word(16'd5);
        chk("t6_full", shadow_full, 1);
        swap = 1'b1; tick(); swap = 1'b0;
        chk("t6_swap_ack", swap_ack, 1);
        feed(16'd2, 2'd3, 32'd1);
        chk("t6_sel3", psum_out, 32'd11);
        feed(16'd2, 2'd0, 32'd1);
        chk("t6_sel0", psum_out, 32'd5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
